// File: rtl/noc_stream_if.sv
// NAP-style data-stream bundle: one beat of data/addr plus packet delimiters,
// moved on a valid/ready handshake.
interface noc_stream_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              sop;
  logic              eop;

  // Source side drives the beat, sink side answers with ready.
  modport master (output valid, data, addr, sop, eop, input ready);
  modport slave  (input valid, data, addr, sop, eop, output ready);
endinterface

// File: rtl/noc_stream_loopback.sv
// Data-stream loopback/sink: buffers rx beats in a FIFO, then either replays
// each packet on tx (honouring tx.ready) or discards it, chosen per packet
// from drop_mode. Mirrors a byte of the last accepted beat on the LEDs and
// keeps wrap-around packet/drop counters for bring-up debug.
module noc_stream_loopback #(
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int LED_W          = 8,
  parameter int LED_LSB        = 24,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             drop_mode,
  noc_stream_if.slave      rx,
  noc_stream_if.master     tx,
  output logic [LED_W-1:0] leds,
  output logic [31:0]      pkt_count,
  output logic [31:0]      drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + ADDR_W + 2;

  // Beat storage; entry layout is {data, addr, sop, eop}.
  logic [ENT_W-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next, count_after_pop;
  logic             rx_ready_reg, rx_ready_next;

  // Head stage: the oldest buffered beat, registered out of the array.
  // head_drop_reg is the packet mode that beat belongs to; mode_valid_reg
  // says a packet mode is currently latched (cleared when its eop pops).
  logic              head_valid_reg, head_valid_next;
  logic              head_drop_reg, head_drop_next;
  logic              mode_valid_reg, mode_valid_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic [ADDR_W-1:0] tx_addr_reg, tx_addr_next;
  logic              tx_sop_reg, tx_sop_next;
  logic              tx_eop_reg, tx_eop_next;

  logic [LED_W-1:0]  led_field_reg, led_field_next;
  logic [31:0]       pkt_count_reg, pkt_count_next;
  logic [31:0]       drop_count_reg, drop_count_next;

  logic              push_en, loop_pop, drop_pop, pop_en;
  logic              load_en, keep_mode, load_drop;
  logic [ENT_W-1:0]  rd_entry;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sop, rd_eop;

  // Handshakes, pointer/occupancy bookkeeping and the registered rx_ready.
  always_comb begin
    push_en         = rx.valid & rx_ready_reg;
    drop_pop        = head_valid_reg & head_drop_reg;
    loop_pop        = tx_valid_reg & tx.ready;
    pop_en          = drop_pop | loop_pop;
    count_after_pop = count_reg - CNT_W'(pop_en);
    count_next      = count_after_pop + CNT_W'(push_en);
    wr_ptr_next     = push_en ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next     = pop_en  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    rx_ready_next   = (count_next < CNT_W'(FIFO_DEPTH));
  end

  // Head refill and packet-mode latching. A new head is only taken from
  // entries already in the array before this edge, so a beat pushed into an
  // empty FIFO needs one extra cycle to reach the head (no bypass path).
  always_comb begin
    rd_entry                         = mem[rd_ptr_next];
    {rd_data, rd_addr, rd_sop, rd_eop} = rd_entry;
    // The latched mode survives this edge unless its eop beat is leaving.
    keep_mode       = mode_valid_reg & ~(pop_en & tx_eop_reg);
    load_en         = (count_after_pop != '0) & (~head_valid_reg | pop_en);
    // sop always re-samples drop_mode; a headless beat with no latched mode
    // (malformed stream) also takes the live drop_mode.
    load_drop       = (keep_mode & ~rd_sop) ? head_drop_reg : drop_mode;
    head_valid_next = (count_after_pop != '0);
    head_drop_next  = head_drop_reg;
    mode_valid_next = mode_valid_reg;
    tx_data_next    = tx_data_reg;
    tx_addr_next    = tx_addr_reg;
    tx_sop_next     = tx_sop_reg;
    tx_eop_next     = tx_eop_reg;
    if (load_en) begin
      head_drop_next  = load_drop;
      mode_valid_next = 1'b1;
      tx_data_next    = rd_data;
      tx_addr_next    = rd_addr;
      tx_sop_next     = rd_sop;
      tx_eop_next     = rd_eop;
    end else if (pop_en & tx_eop_reg) begin
      mode_valid_next = 1'b0;
    end
    tx_valid_next = head_valid_next & ~head_drop_next;
  end

  // LED capture and debug counters.
  always_comb begin
    led_field_next  = led_field_reg;
    pkt_count_next  = pkt_count_reg;
    drop_count_next = drop_count_reg;
    if (push_en) begin
      led_field_next = rx.data[LED_LSB +: LED_W];
      if (rx.eop) begin
        pkt_count_next = pkt_count_reg + 32'd1;
      end
    end
    if (drop_pop & tx_eop_reg) begin
      drop_count_next = drop_count_reg + 32'd1;
    end
  end

  // Array write port; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= {rx.data, rx.addr, rx.sop, rx.eop};
    end
  end

  // State registers; reset discards everything buffered or in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rx_ready_reg   <= 1'b0;
      head_valid_reg <= 1'b0;
      head_drop_reg  <= 1'b0;
      mode_valid_reg <= 1'b0;
      tx_valid_reg   <= 1'b0;
      tx_data_reg    <= '0;
      tx_addr_reg    <= '0;
      tx_sop_reg     <= 1'b0;
      tx_eop_reg     <= 1'b0;
      led_field_reg  <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      rx_ready_reg   <= rx_ready_next;
      head_valid_reg <= head_valid_next;
      head_drop_reg  <= head_drop_next;
      mode_valid_reg <= mode_valid_next;
      tx_valid_reg   <= tx_valid_next;
      tx_data_reg    <= tx_data_next;
      tx_addr_reg    <= tx_addr_next;
      tx_sop_reg     <= tx_sop_next;
      tx_eop_reg     <= tx_eop_next;
      led_field_reg  <= led_field_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign rx.ready   = rx_ready_reg;
  assign tx.valid   = tx_valid_reg;
  assign tx.data    = tx_data_reg;
  assign tx.addr    = tx_addr_reg;
  assign tx.sop     = tx_sop_reg;
  assign tx.eop     = tx_eop_reg;
  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;

  // Per-bit LED drive with optional inversion for active-low boards.
  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      assign leds[gi] = LED_ACTIVE_LOW ? ~led_field_reg[gi] : led_field_reg[gi];
    end
  endgenerate

endmodule
